shim_tx_merge: RTL and testbench
================================

SHIM_TX_MERGE -- requirements
Module: shim_tx_merge

Interface
REQ-001 SHALL have parameter MAX_BURST, default 16, meaning the maximum number of consecutive shim blocks sent per gap before MAC traffic is re-admitted.
REQ-002 SHALL have parameter CNT_W, default 32, meaning the width of the statistics counters.
REQ-003 SHALL have port clk  in  1  clock; all logic is on the rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port mac_d  in  64  MAC 66b block payload.
REQ-006 SHALL have port mac_c  in  2  MAC sync header (2'b10 data, 2'b01 ctrl).
REQ-007 SHALL have port mac_valid  in  1  MAC block offered.
REQ-008 SHALL have port mac_ready  out  1  MAC block accepted this cycle.
REQ-009 SHALL have port shim_empty  in  1  shim FIFO empty flag.
REQ-010 SHALL have port shim_d  in  64  shim FIFO head payload, valid in the same cycle as shim_rd.
REQ-011 SHALL have port shim_c  in  2  shim FIFO head sync header.
REQ-012 SHALL have port shim_rd  out  1  pop the shim FIFO head this cycle.
REQ-013 SHALL have port tx_d  out  64  merged block payload to the scrambler.
REQ-014 SHALL have port tx_c  out  2  merged block sync header.
REQ-015 SHALL have port state_o  out  2  current FSM state.
REQ-016 SHALL have port shim_cnt  out  CNT_W  shim blocks sent, saturating.
REQ-017 SHALL have port mac_cnt  out  CNT_W  MAC blocks sent, saturating.

Function
REQ-018 SHALL classify a MAC block as follows: start = ctrl header and type 8'h78; term = ctrl header and type in {87,99,AA,B4,CC,D2,E1,FF}; idle = ctrl header and type 8'h1E. Type is mac_d[7:0].
REQ-019 SHALL implement FSM states GAP=0, FRAME=1, SHIM=2.
REQ-020 GAP: if shim_empty=0 and (mac_valid=0 or MAC block is idle), SHALL go to SHIM with shim_rd=1 in that same cycle; otherwise mac_ready=1, and an accepted start SHALL go to FRAME.
REQ-021 FRAME: mac_ready SHALL be 1 and shim_rd SHALL be 0; an accepted term SHALL go to GAP; a term arriving while start is still pending SHALL never occur, since start/term are exclusive per block.
REQ-022 SHIM: shim_rd SHALL be 1 while shim_empty=0 and burst_cnt<MAX_BURST, and mac_ready SHALL be 0; the FSM SHALL return to GAP when shim_empty=1 or burst_cnt reaches MAX_BURST.
REQ-023 burst_cnt SHALL increment on each shim_rd and clear on GAP entry; after a MAX_BURST exit, GAP SHALL admit at least one MAC block or idle before re-entering SHIM.
REQ-024 Output SHALL be registered with 1-cycle latency: the shim block when shim_rd=1; else the MAC block when mac_valid&mac_ready; else the idle block (tx_c=2'b01, tx_d=64'h1E).
REQ-025 Idle MAC blocks displaced by shim entry SHALL be consumed (mac_ready=1 the same cycle) so that MAC idles are replaced, never delayed.
REQ-026 A shim block SHALL never be emitted between a start and its term.
REQ-027 shim_cnt SHALL increment per shim_rd and mac_cnt per accepted non-idle MAC block; both SHALL saturate at all-ones without wrapping.
REQ-028 shim_rd SHALL never assert when shim_empty=1.

Reset
REQ-029 Asynchronous reset SHALL force state GAP, burst_cnt=0, shim_cnt=0, mac_cnt=0, tx_c=2'b01, tx_d=64'h1E, with shim_rd=0 and mac_ready=0 while reset is high.
REQ-030 Reset in the middle of a FRAME or SHIM SHALL abandon the burst; the first block after release SHALL be idle.

Structure
REQ-031 The shared package shim_pkg SHALL hold SYNC_DATA, SYNC_CTRL, BT_START, BT_IDLE, the terminate type list, IDLE_BLOCK and the state encodings.
REQ-032 A single combinational sub-module shim_block_classify SHALL produce start/term/idle.

Verification
REQ-033 The FIFO holds 3 blocks and MAC sends only idles -> shim_rd high for 3 cycles, tx shows 3 shim blocks 1 cycle later, shim_cnt=3, state GAP.
REQ-034 MAC start, 5 data blocks, then term, with FIFO non-empty throughout -> no shim_rd during the frame; the shim burst begins in the cycle after the term.
REQ-035 MAX_BURST=4 and 10 blocks queued -> 4 shim blocks, then at least 1 non-shim block, then 4 more.
REQ-036 mac_valid=0 and FIFO empty -> tx_d=64'h1E, tx_c=2'b01 continuously.
REQ-037 Reset asserted during the 2nd block of a shim burst -> outputs return to reset values immediately; no further shim_rd until release; shim_cnt=0.
REQ-038 Counters forced to all-ones minus 1, then 3 blocks sent -> counters hold at all-ones.

Source files
------------

// File: rtl/shim_pkg.sv
// Shared 64b/66b block constants and merge FSM encoding for the shim TX path.
package shim_pkg;

  localparam logic [1:0]  SYNC_DATA  = 2'b10;
  localparam logic [1:0]  SYNC_CTRL  = 2'b01;
  localparam logic [7:0]  BT_START   = 8'h78;
  localparam logic [7:0]  BT_IDLE    = 8'h1E;
  localparam logic [63:0] IDLE_BLOCK = 64'h1E;

  // Terminate block types T0..T7; element 0 is T0.
  localparam int N_TERM = 8;
  localparam logic [N_TERM-1:0][7:0] BT_TERM = {
    8'hFF, 8'hE1, 8'hD2, 8'hCC, 8'hB4, 8'hAA, 8'h99, 8'h87
  };

  typedef enum logic [1:0] {
    ST_GAP   = 2'd0,
    ST_FRAME = 2'd1,
    ST_SHIM  = 2'd2
  } state_e;

endpackage

// File: rtl/shim_block_classify.sv
// Combinational start/terminate/idle decode of one 66b block.
module shim_block_classify
  import shim_pkg::*;
(
  input  logic [1:0] blk_c,
  input  logic [7:0] blk_type,
  output logic       is_start,
  output logic       is_term,
  output logic       is_idle
);

  logic              is_ctrl;
  logic [N_TERM-1:0] term_hit;

  assign is_ctrl = (blk_c == SYNC_CTRL);

  generate
    for (genvar gi = 0; gi < N_TERM; gi++) begin : g_term
      assign term_hit[gi] = (blk_type == BT_TERM[gi]);
    end
  endgenerate

  assign is_start = is_ctrl && (blk_type == BT_START);
  assign is_term  = is_ctrl && (|term_hit);
  assign is_idle  = is_ctrl && (blk_type == BT_IDLE);

endmodule

// File: rtl/shim_tx_merge.sv
// Merges shim FIFO blocks into the inter-frame gaps of the MAC 66b block stream.
// Shim bursts replace MAC idles, never split a frame, and are capped at MAX_BURST per gap.
module shim_tx_merge
  import shim_pkg::*;
#(
  parameter int MAX_BURST = 16,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [63:0]      mac_d,
  input  logic [1:0]       mac_c,
  input  logic             mac_valid,
  output logic             mac_ready,
  input  logic             shim_empty,
  input  logic [63:0]      shim_d,
  input  logic [1:0]       shim_c,
  output logic             shim_rd,
  output logic [63:0]      tx_d,
  output logic [1:0]       tx_c,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] shim_cnt,
  output logic [CNT_W-1:0] mac_cnt
);

  localparam int            BW        = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);

  state_e           state_q;
  logic [BW-1:0]    burst_q;
  logic [BW-1:0]    burst_inc;
  logic             admit_q;
  logic [63:0]      tx_d_q;
  logic [1:0]       tx_c_q;
  logic [CNT_W-1:0] shim_cnt_q;
  logic [CNT_W-1:0] mac_cnt_q;
  logic             rd_en;
  logic             rdy_en;
  logic             mac_acc;
  logic             mac_start;
  logic             mac_term;
  logic             mac_idle;

  shim_block_classify u_classify (
    .blk_c    (mac_c),
    .blk_type (mac_d[7:0]),
    .is_start (mac_start),
    .is_term  (mac_term),
    .is_idle  (mac_idle)
  );

  assign burst_inc = burst_q + 1'b1;
  assign mac_acc   = mac_valid & rdy_en;

  // GAP keeps mac_ready high even while entering SHIM so a displaced idle is dropped, not stalled.
  always_comb begin
    rd_en  = 1'b0;
    rdy_en = 1'b0;
    case (state_q)
      ST_GAP: begin
        rdy_en = 1'b1;
        rd_en  = !admit_q && !shim_empty && (!mac_valid || mac_idle);
      end
      ST_FRAME: rdy_en = 1'b1;
      ST_SHIM:  rd_en  = !shim_empty && (burst_q < BURST_MAX);
      default: ;
    endcase
    if (reset) begin
      rd_en  = 1'b0;
      rdy_en = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_GAP;
      burst_q    <= '0;
      admit_q    <= 1'b0;
      tx_d_q     <= IDLE_BLOCK;
      tx_c_q     <= SYNC_CTRL;
      shim_cnt_q <= '0;
      mac_cnt_q  <= '0;
    end else begin
      if (rd_en) begin
        tx_d_q <= shim_d;
        tx_c_q <= shim_c;
      end else if (mac_acc) begin
        tx_d_q <= mac_d;
        tx_c_q <= mac_c;
      end else begin
        tx_d_q <= IDLE_BLOCK;
        tx_c_q <= SYNC_CTRL;
      end

      if (rd_en && (shim_cnt_q != '1)) shim_cnt_q <= shim_cnt_q + 1'b1;
      if (mac_acc && !mac_idle && (mac_cnt_q != '1)) mac_cnt_q <= mac_cnt_q + 1'b1;

      case (state_q)
        ST_GAP: begin
          if (rd_en) begin
            state_q <= ST_SHIM;
            burst_q <= BW'(1);
          end else begin
            admit_q <= 1'b0;
            if (mac_acc && mac_start) state_q <= ST_FRAME;
          end
        end
        ST_FRAME: begin
          if (mac_acc && mac_term) begin
            state_q <= ST_GAP;
            burst_q <= '0;
          end
        end
        ST_SHIM: begin
          if (rd_en && (burst_inc < BURST_MAX)) begin
            burst_q <= burst_inc;
          end else begin
            // A capped burst forces one MAC/idle slot before the next shim burst.
            state_q <= ST_GAP;
            burst_q <= '0;
            admit_q <= rd_en || (burst_q >= BURST_MAX);
          end
        end
        default: state_q <= ST_GAP;
      endcase
    end
  end

  assign shim_rd   = rd_en;
  assign mac_ready = rdy_en;
  assign tx_d      = tx_d_q;
  assign tx_c      = tx_c_q;
  assign state_o   = state_q;
  assign shim_cnt  = shim_cnt_q;
  assign mac_cnt   = mac_cnt_q;

endmodule

// File: tb/tb_shim_tx_merge.sv
// Randomized and directed bench for shim_tx_merge against a queue-based merge model.
module tb_shim_tx_merge;

  localparam int MB  = 4;
  localparam int CW  = 32;
  localparam int CW2 = 2;
  localparam logic [65:0] IDLE = {2'b01, 64'h1E};

  logic clk = 1'b0;
  logic reset;
  logic [63:0] mac_d;
  logic [1:0]  mac_c;
  logic        mac_valid;
  logic        mac_ready, mac_ready2;
  logic        shim_empty;
  logic [63:0] shim_d;
  logic [1:0]  shim_c;
  logic        shim_rd, shim_rd2;
  logic [63:0] tx_d, tx_d2;
  logic [1:0]  tx_c, tx_c2;
  logic [1:0]  state_o, state_o2;
  logic [CW-1:0]  shim_cnt, mac_cnt;
  logic [CW2-1:0] shim_cnt2, mac_cnt2;

  always #5 clk = ~clk;

  shim_tx_merge #(.MAX_BURST(MB), .CNT_W(CW)) u_dut (
    .clk(clk), .reset(reset), .mac_d(mac_d), .mac_c(mac_c), .mac_valid(mac_valid),
    .mac_ready(mac_ready), .shim_empty(shim_empty), .shim_d(shim_d), .shim_c(shim_c),
    .shim_rd(shim_rd), .tx_d(tx_d), .tx_c(tx_c), .state_o(state_o),
    .shim_cnt(shim_cnt), .mac_cnt(mac_cnt)
  );

  // Narrow counters so saturation is reached within a few blocks.
  shim_tx_merge #(.MAX_BURST(MB), .CNT_W(CW2)) u_sat (
    .clk(clk), .reset(reset), .mac_d(mac_d), .mac_c(mac_c), .mac_valid(mac_valid),
    .mac_ready(mac_ready2), .shim_empty(shim_empty), .shim_d(shim_d), .shim_c(shim_c),
    .shim_rd(shim_rd2), .tx_d(tx_d2), .tx_c(tx_c2), .state_o(state_o2),
    .shim_cnt(shim_cnt2), .mac_cnt(mac_cnt2)
  );

  logic [65:0] shim_q[$];
  logic [65:0] mac_q[$];
  logic [7:0]  term_types [8];
  bit m_frame, m_burst, m_admit, m_acc, e_rd, e_ready, mac_on, rand_mode, last_rd;
  int m_blen, n_checks, n_fail;
  logic [65:0] m_tx;
  longint m_scnt, m_mcnt;

  function automatic bit blk_idle(logic [65:0] b);
    return (b[65:64] == 2'b01) && (b[7:0] == 8'h1E);
  endfunction

  function automatic bit blk_start(logic [65:0] b);
    return (b[65:64] == 2'b01) && (b[7:0] == 8'h78);
  endfunction

  function automatic bit blk_term(logic [65:0] b);
    return (b[65:64] == 2'b01) &&
           (b[7:0] inside {8'h87, 8'h99, 8'hAA, 8'hB4, 8'hCC, 8'hD2, 8'hE1, 8'hFF});
  endfunction

  function automatic logic [65:0] sat(longint v, int w);
    longint lim;
    lim = (longint'(1) << w) - 1;
    return (v > lim) ? 66'(lim) : 66'(v);
  endfunction

  task automatic check(string name, logic [65:0] act, logic [65:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_frame = 0; m_burst = 0; m_admit = 0; m_acc = 0; m_blen = 0;
    m_tx = IDLE; m_scnt = 0; m_mcnt = 0;
  endtask

  task automatic drive();
    shim_empty = (shim_q.size() == 0);
    {shim_c, shim_d} = shim_empty ? 66'h0 : shim_q[0];
    mac_valid = mac_on && (mac_q.size() != 0);
    {mac_c, mac_d} = mac_valid ? mac_q[0] : 66'h0;
  endtask

  // Expected handshakes from the merge rules for the current inputs.
  task automatic predict();
    e_rd = 0; e_ready = 0;
    if (reset) begin
      e_rd = 0; e_ready = 0;
    end else if (m_frame) begin
      e_ready = 1;
    end else if (m_burst) begin
      e_rd = !shim_empty && (m_blen < MB);
    end else begin
      e_ready = 1;
      e_rd = !m_admit && !shim_empty && (!mac_valid || blk_idle({mac_c, mac_d}));
    end
  endtask

  task automatic compare();
    logic [1:0] es;
    es = m_frame ? 2'd1 : (m_burst ? 2'd2 : 2'd0);
    check("shim_rd", shim_rd, e_rd);
    check("mac_ready", mac_ready, e_ready);
    check("tx_block", {tx_c, tx_d}, m_tx);
    check("state", state_o, es);
    check("shim_cnt", shim_cnt, sat(m_scnt, CW));
    check("mac_cnt", mac_cnt, sat(m_mcnt, CW));
    check("sat_shim_rd", shim_rd2, e_rd);
    check("sat_mac_ready", mac_ready2, e_ready);
    check("sat_tx_block", {tx_c2, tx_d2}, m_tx);
    check("sat_state", state_o2, es);
    check("sat_shim_cnt", shim_cnt2, sat(m_scnt, CW2));
    check("sat_mac_cnt", mac_cnt2, sat(m_mcnt, CW2));
  endtask

  task automatic update();
    logic [65:0] blk;
    if (reset) begin
      model_reset();
      return;
    end
    blk = {mac_c, mac_d};
    m_acc = mac_valid && e_ready;
    if (e_rd) begin
      m_tx = shim_q.pop_front();
      m_scnt++;
    end else if (m_acc) m_tx = blk;
    else m_tx = IDLE;
    if (m_acc) begin
      if (!blk_idle(blk)) m_mcnt++;
      mac_q.delete(0);
    end
    if (m_frame) begin
      if (m_acc && blk_term(blk)) m_frame = 0;
    end else if (m_burst) begin
      if (e_rd) begin
        m_blen++;
        if (m_blen >= MB) begin m_burst = 0; m_admit = 1; m_blen = 0; end
      end else begin
        m_burst = 0; m_blen = 0;
      end
    end else if (e_rd) begin
      m_burst = 1; m_blen = 1;
    end else begin
      m_admit = 0;
      if (m_acc && blk_start(blk)) m_frame = 1;
    end
  endtask

  task automatic gen();
    if ($urandom_range(0, 2) == 0 && shim_q.size() < 8)
      shim_q.push_back({($urandom_range(0, 1) != 0) ? 2'b10 : 2'b01, $urandom, $urandom});
    if (mac_q.size() < 4) begin
      if ($urandom_range(0, 1) != 0) begin
        repeat ($urandom_range(1, 4)) mac_q.push_back(IDLE);
      end else begin
        mac_q.push_back({2'b01, $urandom, 24'($urandom), 8'h78});
        repeat ($urandom_range(0, 8)) mac_q.push_back({2'b10, $urandom, $urandom});
        mac_q.push_back({2'b01, $urandom, 24'($urandom), term_types[$urandom_range(0, 7)]});
      end
    end
    if (!(mac_valid && !m_acc)) mac_on = ($urandom_range(0, 3) != 0);
  endtask

  task automatic cycle();
    @(negedge clk);
    predict();
    compare();
    last_rd = shim_rd;
    @(posedge clk);
    update();
    #1;
    if (rand_mode) gen();
    drive();
  endtask

  task automatic quiet();
    int n;
    n = 0;
    rand_mode = 0;
    mac_on = 1;
    drive();
    while ((mac_q.size() != 0 || shim_q.size() != 0 || m_frame || m_burst) && n < 500) begin
      cycle();
      n++;
    end
    check("drain_bound", 66'(n < 500), 66'(1));
    mac_on = 0;
    drive();
    repeat (3) cycle();
  endtask

  initial begin
    logic [3:0]  pat4;
    logic [7:0]  pat8;
    logic [12:0] pat13;
    term_types = '{8'h87, 8'h99, 8'hAA, 8'hB4, 8'hCC, 8'hD2, 8'hE1, 8'hFF};
    n_checks = 0; n_fail = 0;
    rand_mode = 0; mac_on = 0;
    reset = 1'b1;
    model_reset();
    drive();
    #1;
    check("rst_tx_d", tx_d, 64'h1E);
    check("rst_tx_c", tx_c, 2'b01);
    check("rst_state", state_o, 2'd0);
    check("rst_ready", mac_ready, 1'b0);
    check("rst_cnts", {shim_cnt, mac_cnt}, 66'h0);
    repeat (2) cycle();
    reset = 1'b0;

    // Three shim blocks against a MAC idle stream.
    repeat (20) mac_q.push_back(IDLE);
    mac_on = 1;
    for (int i = 1; i <= 3; i++) shim_q.push_back({2'b10, 56'h0, 8'(8'hA0 + i)});
    drive();
    pat4 = '0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      pat4 = {pat4[2:0], last_rd};
      if (i < 3) check("fill3_tx", {tx_c, tx_d}, {2'b10, 56'h0, 8'(8'hA1 + i)});
    end
    check("fill3_rd_pattern", pat4, 4'b1110);
    check("fill3_shim_cnt", shim_cnt, 3);
    check("fill3_state", state_o, 2'd0);
    check("fill3_sat_shim_cnt", shim_cnt2, 2'b11);
    quiet();

    // Nothing to send: continuous idles.
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("quiet_tx_d", tx_d, 64'h1E);
      check("quiet_tx_c", tx_c, 2'b01);
    end

    // Frame with shim pending throughout: burst waits for the term.
    mac_q.push_back({2'b01, 56'h0, 8'h78});
    for (int i = 0; i < 5; i++) mac_q.push_back({2'b10, 56'h0, 8'(8'h10 + i)});
    mac_q.push_back({2'b01, 56'h0, 8'h87});
    repeat (6) mac_q.push_back(IDLE);
    for (int i = 0; i < 3; i++) shim_q.push_back({2'b01, 56'h0, 8'(8'hB0 + i)});
    mac_on = 1;
    drive();
    pat8 = '0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      pat8 = {pat8[6:0], last_rd};
    end
    check("frame_rd_pattern", pat8, 8'b0000_0001);
    check("frame_mac_cnt", mac_cnt, 7);
    check("frame_sat_mac_cnt", mac_cnt2, 2'b11);
    quiet();

    // Ten queued blocks with a burst cap of four.
    for (int i = 0; i < 10; i++) shim_q.push_back({2'b10, 56'h0, 8'(8'hC0 + i)});
    repeat (20) mac_q.push_back(IDLE);
    mac_on = 1;
    drive();
    pat13 = '0;
    for (int i = 0; i < 13; i++) begin
      cycle();
      pat13 = {pat13[11:0], last_rd};
    end
    check("cap_rd_pattern", pat13, 13'b1111_0_1111_0_110);
    check("cap_shim_cnt", shim_cnt, 16);
    check("cap_sat_shim_cnt", shim_cnt2, 2'b11);
    quiet();

    // Reset during the second block of a burst.
    for (int i = 0; i < 5; i++) shim_q.push_back({2'b10, 56'h0, 8'(8'hD0 + i)});
    drive();
    cycle();
    @(negedge clk);
    check("burst2_rd", shim_rd, 1'b1);
    check("burst2_state", state_o, 2'd2);
    #1 reset = 1'b1;
    #1;
    check("midrst_tx_d", tx_d, 64'h1E);
    check("midrst_tx_c", tx_c, 2'b01);
    check("midrst_shim_rd", shim_rd, 1'b0);
    check("midrst_ready", mac_ready, 1'b0);
    check("midrst_state", state_o, 2'd0);
    check("midrst_shim_cnt", shim_cnt, 0);
    check("midrst_mac_cnt", mac_cnt, 0);
    model_reset();
    repeat (2) cycle();
    reset = 1'b0;
    drive();
    #1;
    check("release_tx_d", tx_d, 64'h1E);
    check("release_rd", shim_rd, 1'b1);
    quiet();

    // Long randomized run against the model.
    rand_mode = 1;
    repeat (3000) cycle();
    quiet();
    check("final_sat_shim_cnt", shim_cnt2, 2'b11);
    check("final_sat_mac_cnt", mac_cnt2, 2'b11);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
